// File: rtl/fir_cmp_sequencer.sv
// +----------------------------------------------------------------------------+
// | fir_cmp_sequencer                                                          |
// | Paced sample sequencer and output comparator for the two FIR forms.        |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module fir_cmp_sequencer #(
    parameter int WIDTH     = 24,
    parameter int PERIOD    = 128,
    parameter int LAT       = 3,
    parameter int N_SAMPLES = 800
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             smp_valid_i,
    input  logic [WIDTH-1:0] smp_data_i,
    output logic             smp_ready_o,
    output logic [WIDTH-1:0] fir_in_o,
    output logic             fir_ready_o,
    input  logic [WIDTH-1:0] fir_out_a_i,
    input  logic [WIDTH-1:0] fir_out_b_i,
    output logic             res_valid_o,
    output logic [WIDTH-1:0] res_data_o,
    output logic             res_mismatch_o,
    output logic [16:0]      smp_cnt_o,
    output logic [16:0]      err_cnt_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int                SLOT_W   = $clog2(PERIOD);
    localparam logic [SLOT_W-1:0] SLOT_MAX = SLOT_W'(PERIOD - 1);
    localparam logic [SLOT_W-1:0] LAT_M1   = SLOT_W'(LAT - 1);
    localparam logic [16:0]       N_LAST   = 17'(N_SAMPLES);
    localparam logic [16:0]       ERR_MAX  = 17'h1FFFF;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_HOLD    = 3'd2,
        S_STROBE  = 3'd3,
        S_WAIT    = 3'd4,
        S_CAPTURE = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    state_t             state_q, state_d;
    logic [SLOT_W-1:0]  slot_cnt_q, slot_cnt_d;
    logic               expired_q, expired_d;
    logic [WIDTH-1:0]   fir_in_q, fir_in_d;
    logic               res_valid_q, res_valid_d;
    logic [WIDTH-1:0]   res_data_q, res_data_d;
    logic               res_mis_q, res_mis_d;
    logic [16:0]        smp_cnt_q, smp_cnt_d;
    logic [16:0]        err_cnt_q, err_cnt_d;
    logic [16:0]        smp_cnt_inc;
    logic               mismatch;

    assign smp_cnt_inc = smp_cnt_q + 17'd1;
    assign mismatch    = (fir_out_a_i != fir_out_b_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            slot_cnt_q  <= '0;
            expired_q   <= 1'b0;
            fir_in_q    <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_mis_q   <= 1'b0;
            smp_cnt_q   <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            slot_cnt_q  <= slot_cnt_d;
            expired_q   <= expired_d;
            fir_in_q    <= fir_in_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_mis_q   <= res_mis_d;
            smp_cnt_q   <= smp_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        slot_cnt_d  = (slot_cnt_q == SLOT_MAX) ? slot_cnt_q : slot_cnt_q + SLOT_W'(1);
        expired_d   = expired_q;
        fir_in_d    = fir_in_q;
        res_valid_d = 1'b0;
        res_data_d  = res_data_q;
        res_mis_d   = res_mis_q;
        smp_cnt_d   = smp_cnt_q;
        err_cnt_d   = err_cnt_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    state_d   = S_FETCH;
                    expired_d = 1'b1;
                    smp_cnt_d = '0;
                    err_cnt_d = '0;
                end
            end
            S_FETCH: begin
                if (smp_valid_i) begin
                    fir_in_d = smp_data_i;
                    state_d  = S_HOLD;
                end
            end
            S_HOLD: begin
                // Slot counter is cleared on entry so STROBE is slot cycle 0.
                if (expired_q || (slot_cnt_q == SLOT_MAX)) begin
                    state_d    = S_STROBE;
                    expired_d  = 1'b0;
                    slot_cnt_d = '0;
                end
            end
            S_STROBE: begin
                state_d = (LAT == 1) ? S_CAPTURE : S_WAIT;
            end
            S_WAIT: begin
                if (slot_cnt_q == LAT_M1) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                res_valid_d = 1'b1;
                res_data_d  = fir_out_a_i;
                res_mis_d   = mismatch;
                smp_cnt_d   = smp_cnt_inc;
                if (mismatch && (err_cnt_q != ERR_MAX)) begin
                    err_cnt_d = err_cnt_q + 17'd1;
                end
                state_d = (smp_cnt_inc == N_LAST) ? S_DONE : S_FETCH;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign smp_ready_o    = (state_q == S_FETCH);
    assign fir_ready_o    = (state_q == S_STROBE);
    assign busy_o         = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done_o         = (state_q == S_DONE);
    assign fir_in_o       = fir_in_q;
    assign res_valid_o    = res_valid_q;
    assign res_data_o     = res_data_q;
    assign res_mismatch_o = res_mis_q;
    assign smp_cnt_o      = smp_cnt_q;
    assign err_cnt_o      = err_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_fir_cmp_sequencer.sv
// +----------------------------------------------------------------------------+
// | tb_fir_cmp_sequencer                                                       |
// | Directed bench for fir_cmp_sequencer with PERIOD=8, LAT=3, N_SAMPLES=4.    |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_fir_cmp_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        smp_valid = 1'b0;
    logic [23:0] smp_data = '0;
    logic        smp_ready;
    logic [23:0] fir_in;
    logic        fir_ready;
    logic [23:0] fa = 24'h5A5A5A;
    logic [23:0] fb = 24'h5A5A5A;
    logic        res_valid;
    logic [23:0] res_data;
    logic        res_mis;
    logic [16:0] smp_cnt;
    logic [16:0] err_cnt;
    logic        busy;
    logic        done;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fir_cmp_sequencer #(
        .WIDTH(24), .PERIOD(8), .LAT(3), .N_SAMPLES(4)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start),
        .smp_valid_i(smp_valid), .smp_data_i(smp_data), .smp_ready_o(smp_ready),
        .fir_in_o(fir_in), .fir_ready_o(fir_ready),
        .fir_out_a_i(fa), .fir_out_b_i(fb),
        .res_valid_o(res_valid), .res_data_o(res_data), .res_mismatch_o(res_mis),
        .smp_cnt_o(smp_cnt), .err_cnt_o(err_cnt), .busy_o(busy), .done_o(done)
    );

    // Filter model: outputs are valid only during slot cycle LAT, junk otherwise.
    logic       model_clr = 1'b0;
    logic [7:0] flip_mask = '0;
    int         strobe_idx = 0;
    logic [1:0] pipe = '0;

    always @(posedge clk) begin
        if (model_clr) strobe_idx <= 0;
        else if (fir_ready) strobe_idx <= strobe_idx + 1;
        pipe <= {pipe[0], fir_ready};
        if (pipe[1]) begin
            fa <= fir_in;
            fb <= fir_in ^ {23'd0, flip_mask[strobe_idx[2:0]]};
        end else begin
            fa <= 24'h5A5A5A;
            fb <= 24'h5A5A5A;
        end
    end

    logic [23:0] smp_vec [0:7];
    int          st_t [0:7];
    int          rv_t [0:7];
    logic [23:0] rv_d [0:7];
    logic        rv_m [0:7];
    logic [16:0] rv_sc [0:7];
    logic [16:0] rv_ec [0:7];
    int          acc_t [0:7];
    int          ns, nr, na, done_t, stall_bad;
    logic [16:0] sc_at1;
    logic        done_at1;
    bit          timed_out;

    // Drives one run from cycle 0 (start) and records events by cycle number.
    task automatic run_seq(input int stall_after, input int stall_len,
                           input int pulse_at, input int abort_at);
        logic pend;
        int   stall_left;
        bit   stalled;
        ns = 0; nr = 0; na = 0; done_t = -1; stall_bad = 0; timed_out = 0;
        stall_left = 0; stalled = 0;
        @(posedge clk); #1;
        model_clr = 1'b1;
        start     = 1'b1;
        smp_valid = 1'b1;
        smp_data  = smp_vec[0];
        pend      = smp_ready && smp_valid;
        for (int c = 1; c <= 300; c++) begin
            @(posedge clk); #1;
            model_clr = 1'b0;
            start = (c == pulse_at);
            if (pend) begin
                if (na < 8) acc_t[na] = c - 1;
                na++;
                smp_data = smp_vec[na % 8];
            end
            if (c == 1) begin
                sc_at1   = smp_cnt;
                done_at1 = done;
            end
            if (fir_ready) begin
                if (ns < 8) st_t[ns] = c;
                ns++;
            end
            if (res_valid) begin
                if (nr < 8) begin
                    rv_t[nr] = c; rv_d[nr] = res_data; rv_m[nr] = res_mis;
                    rv_sc[nr] = smp_cnt; rv_ec[nr] = err_cnt;
                end
                nr++;
            end
            if (done) begin
                done_t = c;
                break;
            end
            if (c == abort_at) return;
            if (stall_len > 0 && !stalled && nr == stall_after) begin
                stalled = 1;
                stall_left = stall_len;
            end
            if (stall_left > 0) begin
                smp_valid = 1'b0;
                if (!smp_ready || fir_in !== smp_vec[na-1]) stall_bad++;
                stall_left--;
            end else begin
                smp_valid = 1'b1;
            end
            pend = smp_ready && smp_valid;
        end
        if (done_t < 0 && abort_at < 0) timed_out = 1;
        smp_valid = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({fir_in, fir_ready, smp_ready, res_valid, res_data, res_mis, smp_cnt, err_cnt, busy, done} !== '0) begin
            failures++;
            $display("FAIL reset_state got fir_in=%h busy=%b done=%b smp_cnt=%0d exp all zero", fir_in, busy, done, smp_cnt);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        int exp_st [4] = '{3, 11, 19, 27};
        int exp_rv [4] = '{7, 15, 23, 31};
        logic [23:0] exp_d [4] = '{24'h000001, 24'hFFFFFE, 24'h000003, 24'hFFFFFC};
        flip_mask = '0;
        smp_vec[0] = 24'h000001; smp_vec[1] = 24'hFFFFFE;
        smp_vec[2] = 24'h000003; smp_vec[3] = 24'hFFFFFC;
        run_seq(-1, 0, -1, -1);
        checks++;
        if (timed_out || ns != 4 || nr != 4) begin
            failures++;
            $display("FAIL basic_counts got strobes=%0d results=%0d timeout=%0d exp 4 4 0", ns, nr, timed_out);
        end
        checks++;
        if (acc_t[0] != 1) begin
            failures++;
            $display("FAIL basic_first_accept got=%0d exp=1", acc_t[0]);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (st_t[i] != exp_st[i] || rv_t[i] != exp_rv[i] || rv_d[i] !== exp_d[i] || rv_m[i] !== 1'b0) begin
                failures++;
                $display("FAIL basic_sample[%0d] got strobe=%0d res=%0d data=%h mis=%b exp %0d %0d %h 0",
                         i, st_t[i], rv_t[i], rv_d[i], rv_m[i], exp_st[i], exp_rv[i], exp_d[i]);
            end
        end
        checks++;
        if (done_t != 31 || smp_cnt !== 17'd4 || err_cnt !== 17'd0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_end got done_t=%0d smp_cnt=%0d err_cnt=%0d busy=%b exp 31 4 0 0", done_t, smp_cnt, err_cnt, busy);
        end
    endtask

    task automatic test_mismatch;
        logic        exp_m [4]  = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [16:0] exp_ec [4] = '{17'd0, 17'd1, 17'd1, 17'd2};
        flip_mask = 8'b0001_0100;
        run_seq(-1, 0, -1, -1);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rv_m[i] !== exp_m[i] || rv_ec[i] !== exp_ec[i] || rv_sc[i] !== 17'(i + 1)) begin
                failures++;
                $display("FAIL mismatch[%0d] got mis=%b err=%0d smp=%0d exp %b %0d %0d",
                         i, rv_m[i], rv_ec[i], rv_sc[i], exp_m[i], exp_ec[i], i + 1);
            end
        end
        checks++;
        if (timed_out || err_cnt !== 17'd2 || done !== 1'b1) begin
            failures++;
            $display("FAIL mismatch_final got err_cnt=%0d done=%b exp 2 1", err_cnt, done);
        end
        flip_mask = '0;
    endtask

    task automatic test_stall;
        run_seq(2, 20, -1, -1);
        checks++;
        if (stall_bad != 0) begin
            failures++;
            $display("FAIL stall_hold got violations=%0d exp=0", stall_bad);
        end
        checks++;
        if (acc_t[2] != 35 || st_t[2] != acc_t[2] + 2 || st_t[2] - st_t[1] <= 8) begin
            failures++;
            $display("FAIL stall_strobe got accept=%0d strobe=%0d prev=%0d exp 35 37 >8 apart", acc_t[2], st_t[2], st_t[1]);
        end
        checks++;
        if (timed_out || st_t[3] != 45 || rv_t[3] != 49 || done_t != 49 || smp_cnt !== 17'd4) begin
            failures++;
            $display("FAIL stall_tail got strobe4=%0d res4=%0d done=%0d smp_cnt=%0d exp 45 49 49 4", st_t[3], rv_t[3], done_t, smp_cnt);
        end
    endtask

    task automatic test_start;
        int exp_rv [4] = '{7, 15, 23, 31};
        checks++;
        if (done !== 1'b1 || smp_cnt !== 17'd4) begin
            failures++;
            $display("FAIL start_pre got done=%b smp_cnt=%0d exp 1 4", done, smp_cnt);
        end
        run_seq(-1, 0, 10, -1);
        checks++;
        if (sc_at1 !== 17'd0 || done_at1 !== 1'b0) begin
            failures++;
            $display("FAIL start_clear got smp_cnt=%0d done=%b exp 0 0", sc_at1, done_at1);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rv_t[i] != exp_rv[i]) begin
                failures++;
                $display("FAIL start_midrun_res[%0d] got=%0d exp=%0d", i, rv_t[i], exp_rv[i]);
            end
        end
        checks++;
        if (timed_out || nr != 4 || smp_cnt !== 17'd4 || done !== 1'b1) begin
            failures++;
            $display("FAIL start_rerun got results=%0d smp_cnt=%0d done=%b exp 4 4 1", nr, smp_cnt, done);
        end
    endtask

    task automatic test_reset_midrun;
        int bad;
        run_seq(-1, 0, -1, 12);
        checks++;
        if (busy !== 1'b1 || fir_in !== 24'hFFFFFE || smp_cnt !== 17'd1) begin
            failures++;
            $display("FAIL rst_pre got busy=%b fir_in=%h smp_cnt=%0d exp 1 fffffe 1", busy, fir_in, smp_cnt);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({fir_in, fir_ready, smp_ready, res_valid, res_data, res_mis, smp_cnt, err_cnt, busy, done} !== '0) begin
            failures++;
            $display("FAIL rst_async got fir_in=%h res_data=%h smp_cnt=%0d busy=%b exp all zero", fir_in, res_data, smp_cnt, busy);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        smp_valid = 1'b1;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (res_valid || fir_ready || busy || smp_ready) bad++;
        end
        smp_valid = 1'b0;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL rst_quiet got active_cycles=%0d exp=0", bad);
        end
    endtask

    task automatic test_neg_full;
        smp_vec[0] = 24'h800000; smp_vec[1] = 24'h7FFFFF;
        smp_vec[2] = 24'hFFFFFF; smp_vec[3] = 24'h000000;
        run_seq(-1, 0, -1, -1);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rv_d[i] !== smp_vec[i] || rv_m[i] !== 1'b0) begin
                failures++;
                $display("FAIL negfs[%0d] got data=%h mis=%b exp %h 0", i, rv_d[i], rv_m[i], smp_vec[i]);
            end
        end
        checks++;
        if (timed_out || err_cnt !== 17'd0 || smp_cnt !== 17'd4) begin
            failures++;
            $display("FAIL negfs_final got err_cnt=%0d smp_cnt=%0d exp 0 4", err_cnt, smp_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mismatch();
        test_stall();
        test_start();
        test_reset_midrun();
        test_neg_full();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fir_cmp_sequencer.md
# fir_cmp_sequencer

Sample-rate sequencer for the FIR comparison datapath. It pulls input samples from a source over a valid/ready handshake and drives one shared `input_sig`/`ready` pair into both FIR implementations: the direct form and the separated form. It captures both filter outputs a fixed latency later, compares them and counts samples and mismatches. A run ends after a programmed number of samples. The block replaces the free-running 7-bit slot counter used in the FIR test socket with a controlled, restartable run.

## Interface
- `WIDTH`, 24, sample width (signed, two's complement)
- `PERIOD`, 128, cycles between consecutive `fir_ready` strobes; must be ≥ `LAT`+3
- `LAT`, 3, cycles from the `fir_ready` strobe to the filter outputs being valid
- `N_SAMPLES`, 800, samples per run, range 1..131071
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  one-cycle request to begin a run
- `smp_valid`  in  1  source sample valid
- `smp_data`  in  WIDTH  source sample, signed
- `smp_ready`  out  1  sequencer can accept a sample
- `fir_in`  out  WIDTH  to `input_sig` of both filters
- `fir_ready`  out  1  one-cycle strobe to `ready` of both filters
- `fir_out_a`  in  WIDTH  direct-form filter output
- `fir_out_b`  in  WIDTH  separated-form filter output
- `res_valid`  out  1  one-cycle result strobe
- `res_data`  out  WIDTH  captured `fir_out_a`
- `res_mismatch`  out  1  captured `fir_out_a != fir_out_b`; qualified by `res_valid`
- `smp_cnt`  out  17  samples captured in the current run
- `err_cnt`  out  17  mismatches in the current run; saturates at 131071
- `busy`  out  1  run in progress
- `done`  out  1  run complete (level)

## Operation
States: IDLE, FETCH, HOLD, STROBE, WAIT, CAPTURE, DONE.
- **IDLE / DONE**
  - `start`=1 clears `smp_cnt`, `err_cnt` and `done`.
  - Next state is FETCH, with the slot-expired flag set so the first strobe is not delayed.
- **FETCH**
  - `smp_ready`=1.
  - On `smp_valid & smp_ready`, `smp_data` is registered into `fir_in`, then go to HOLD.
  - A stalled source stretches the slot with no limit.
- **HOLD**
  - Go to STROBE on the cycle after `slot_cnt == PERIOD-1`, or immediately if the slot-expired flag is set.
  - The flag clears when STROBE is entered.
- **STROBE**
  - Lasts one cycle with `fir_ready`=1.
  - `slot_cnt` is reset to 0 in this cycle (slot cycle 0).
- **WAIT**
  - Runs until `slot_cnt == LAT`, then go to CAPTURE.
- **CAPTURE** (slot cycle `LAT`)
  - Sample `fir_out_a` and `fir_out_b`.
  - `smp_cnt` += 1.
  - `err_cnt` += 1 on mismatch, saturating.
  - Next state is DONE if the new `smp_cnt == N_SAMPLES`, else FETCH.
- `slot_cnt` increments every cycle outside STROBE and saturates at `PERIOD-1`.
- `fir_in` holds its value until the next accepted sample, so it is stable through STROBE..CAPTURE.
- Comparison is a full `WIDTH`-bit equality check; sign is irrelevant.
- `busy`=1 in FETCH, HOLD, STROBE, WAIT and CAPTURE.
- `done`=1 in DONE only.
- `start` while `busy` is ignored.
- `start` in DONE restarts the run with cleared counters.
- Reset values (asynchronous):
  - state IDLE
  - `fir_in`=0, `fir_ready`=0, `smp_ready`=0
  - `res_valid`=0, `res_data`=0, `res_mismatch`=0
  - `smp_cnt`=0, `err_cnt`=0
  - `busy`=0, `done`=0
- Reset mid-run aborts the run immediately. A strobe in flight is dropped and no result is emitted.

## Timing
- Strobe spacing:
  - With the source always valid, `fir_ready` strobes are exactly `PERIOD` cycles apart.
  - With a stalled source, spacing is ≥ `PERIOD`.
- Sample acceptance:
  - The first sample is accepted 1 cycle after `start`.
  - The first strobe comes 2 cycles after acceptance (HOLD, then STROBE).
- Results:
  - `res_valid`, `res_data` and `res_mismatch` are registered: they appear at slot cycle `LAT+1`, one cycle after CAPTURE.
  - `smp_cnt` and `err_cnt` update at the same edge as `res_valid`.
- FETCH begins at slot cycle `LAT+1`, so the next sample is normally accepted well before the slot ends.
- `done` rises on the same edge as the final `res_valid`.
- `fir_ready` is never asserted in IDLE, FETCH, HOLD or DONE.

## Test plan
- **Basic run:** `N_SAMPLES`=4, `PERIOD`=8, `LAT`=3, source always valid with samples 1, -2, 3, -4, outputs a=b.
  - Strobes at cycles t, t+8, t+16, t+24.
  - `res_valid` at t+4, t+12, t+20, t+28.
  - `err_cnt`=0, `smp_cnt`=4, `done`=1 at t+28.
- **Mismatch counting:** force b = a ^ 1 on samples 2 and 4.
  - `res_mismatch`=1 exactly on the 2nd and 4th `res_valid`.
  - Final `err_cnt`=2.
- **Source stall:** hold `smp_valid` low for 20 cycles after the 2nd capture.
  - `smp_ready` stays high throughout.
  - The 3rd strobe comes 2 cycles after acceptance, with spacing > 8.
  - `fir_in` does not change until acceptance.
- **Start handling:**
  - `start` pulsed mid-run changes nothing.
  - `start` in DONE clears the counters and a second run of 4 samples completes with `smp_cnt`=4.
- **Reset mid-run:** assert `rst_n`=0 in WAIT.
  - All outputs read 0 asynchronously.
  - After release, no `res_valid` appears until a new `start`.
- **Negative full-scale:** input -8388608 with a=b=-8388608.
  - `res_data`=-8388608 and `res_mismatch`=0.
